// File: rtl/icache_pkg.sv
// Shared sizing, PC field split and FSM encoding for the direct-mapped instruction cache.
// Latency: none (types and constants only); backpressure: n/a.
package icache_pkg;
  localparam int INDEX_BITS  = 3;
  localparam int ADDR_BITS   = 10;
  localparam int OFFSET_BITS = 4;
  localparam int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;
  localparam int LINES       = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_READ = 2'd1,
    ST_UPDATE   = 2'd2
  } state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [1:0]            word;
    logic [1:0]            byte_sel;
  } pc_fields_t;

  function automatic pc_fields_t split_pc(input logic [ADDR_BITS-1:0] addr);
    return pc_fields_t'(addr);
  endfunction
endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: combinational read + hit compare, synchronous fill and valid clear.
// Latency: read 0 cycles, write visible next cycle; backpressure: none, RESET beats a fill.
module icache_line_array
  import icache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [BLOCK_BITS-1:0] wr_data,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic [BLOCK_BITS-1:0] rd_data,
  output logic                  hit
);
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_store  [LINES];
  logic [BLOCK_BITS-1:0] data_store [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tags and data carry no reset; a fill coinciding with reset is dropped entirely.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_store[wr_index]  <= wr_tag;
      data_store[wr_index] <= wr_data;
    end
  end

  assign rd_data = data_store[rd_index];
  assign hit     = valid[rd_index] && (tag_store[rd_index] == rd_tag);
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped I-cache: hits return same cycle, misses refill one 16-byte block.
// Latency: hit 0 cycles, miss N+3 cycles of BUSYWAIT; backpressure: stalls CPU, waits on MEM_BUSYWAIT.
module instruction_cache
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  output logic [WORD_BITS-1:0]  INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [5:0]            MEM_ADDRESS,
  input  logic [BLOCK_BITS-1:0] MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);
  state_t                state, next_state;
  pc_fields_t            pc_f;
  logic                  hit;
  logic                  fill;
  logic [BLOCK_BITS-1:0] line_data;
  logic                  unused_pc_bits;

  assign pc_f           = split_pc(PC[ADDR_BITS-1:0]);
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], pc_f.byte_sel};

  icache_line_array u_lines (
    .clk      (CLK),
    .reset    (RESET),
    .wr_en    (fill),
    .wr_index (pc_f.index),
    .wr_tag   (pc_f.tag),
    .wr_data  (MEM_READDATA),
    .rd_index (pc_f.index),
    .rd_tag   (pc_f.tag),
    .rd_data  (line_data),
    .hit      (hit)
  );

  assign INSTRUCTION = line_data[{pc_f.word, 5'd0} +: WORD_BITS];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    BUSYWAIT    = 1'b1;
    MEM_READ    = 1'b0;
    MEM_ADDRESS = '0;
    fill        = 1'b0;
    case (state)
      ST_IDLE: begin
        BUSYWAIT = !hit;
        if (!hit) next_state = ST_MEM_READ;
      end
      ST_MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {pc_f.tag, pc_f.index};
        if (!MEM_BUSYWAIT) begin
          fill       = 1'b1;
          next_state = ST_UPDATE;
        end
      end
      // One extra stall cycle so the freshly written line is read back as a hit.
      ST_UPDATE: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end
endmodule
